// File: rtl/inst_fetcher.sv
// Instruction fetcher: a single-outstanding fetch FSM that feeds a circular queue
// of {pc, predicted next pc, instruction} entries toward the issuer, predicting JAL targets.
module inst_fetcher #(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        is_any_full,
    output logic        ready_to_issuer,
    output logic [31:0] pc_to_issuer,
    output logic [31:0] next_pc_to_issuer,
    output logic [31:0] inst_to_issuer,
    output logic        req_to_mem_ctrl,
    output logic [31:0] addr_to_mem_ctrl,
    input  logic        valid_from_mem_ctrl,
    input  logic [31:0] inst_from_mem_ctrl,
    input  logic        reset_from_rob_bus,
    input  logic [31:0] target_pc_from_rob_bus
);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [31:0]      pc_q_r   [QUEUE_DEPTH];
    logic [31:0]      npc_q_r  [QUEUE_DEPTH];
    logic [31:0]      inst_q_r [QUEUE_DEPTH];
    logic [PTR_W-1:0] head_r, tail_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      fetch_pc_r, fetch_pc_s;
    logic [31:0]      addr_r, addr_s;
    logic             req_r, req_s;
    logic             enq_s, deq_s, flush_s;
    logic [31:0]      pred_s;

    // JAL jumps to pc + J-immediate; everything else (branches, JALR included) falls through.
    function automatic logic [31:0] predict_next(input logic [31:0] pc, input logic [31:0] inst);
        logic [31:0] imm;
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        if (inst[6:0] == 7'b1101111) begin
            predict_next = pc + imm;
        end else begin
            predict_next = pc + 32'd4;
        end
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(QUEUE_DEPTH - 1)) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = p + PTR_W'(1'b1);
        end
    endfunction

    assign pred_s  = predict_next(fetch_pc_r, inst_from_mem_ctrl);
    assign flush_s = rdy && reset_from_rob_bus;
    assign deq_s   = rdy && ready_to_issuer && !is_any_full && !reset_from_rob_bus;

    assign req_to_mem_ctrl  = req_r;
    assign addr_to_mem_ctrl = addr_r;

    // Head of queue presented to the issuer; zeroed when empty.
    always_comb begin
        if (count_r != {CNT_W{1'b0}}) begin
            ready_to_issuer   = 1'b1;
            pc_to_issuer      = pc_q_r[head_r];
            next_pc_to_issuer = npc_q_r[head_r];
            inst_to_issuer    = inst_q_r[head_r];
        end else begin
            ready_to_issuer   = 1'b0;
            pc_to_issuer      = 32'd0;
            next_pc_to_issuer = 32'd0;
            inst_to_issuer    = 32'd0;
        end
    end

    // Fetch FSM next-state and request/fetch-pc updates.
    always_comb begin
        state_s    = state_r;
        req_s      = req_r;
        addr_s     = addr_r;
        fetch_pc_s = fetch_pc_r;
        enq_s      = 1'b0;
        if (rdy) begin
            case (state_r)
                IDLE: begin
                    if (flush_s) begin
                        fetch_pc_s = target_pc_from_rob_bus;
                        req_s      = 1'b0;
                    end else if (count_r < CNT_W'(QUEUE_DEPTH)) begin
                        state_s = FETCH;
                        req_s   = 1'b1;
                        addr_s  = fetch_pc_r;
                    end else begin
                        req_s = 1'b0;
                    end
                end
                FETCH: begin
                    if (flush_s) begin
                        fetch_pc_s = target_pc_from_rob_bus;
                        req_s      = 1'b0;
                        if (valid_from_mem_ctrl) begin
                            state_s = IDLE;
                        end else begin
                            state_s = DISCARD;
                        end
                    end else if (valid_from_mem_ctrl) begin
                        enq_s      = 1'b1;
                        fetch_pc_s = pred_s;
                        req_s      = 1'b0;
                        state_s    = IDLE;
                    end else begin
                        req_s = 1'b1;
                    end
                end
                DISCARD: begin
                    req_s = 1'b0;
                    if (flush_s) begin
                        fetch_pc_s = target_pc_from_rob_bus;
                    end else begin
                        fetch_pc_s = fetch_pc_r;
                    end
                    // The stale pulse always retires DISCARD, even alongside a flush:
                    // with one request outstanding no further pulse would ever come.
                    if (valid_from_mem_ctrl) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DISCARD;
                    end
                end
                default: begin
                    state_s = IDLE;
                    req_s   = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM state, request line and fetch pc registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            req_r      <= 1'b0;
            addr_r     <= 32'd0;
            fetch_pc_r <= 32'd0;
        end else begin
            state_r    <= state_s;
            req_r      <= req_s;
            addr_r     <= addr_s;
            fetch_pc_r <= fetch_pc_s;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (flush_s) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (enq_s) begin
                tail_r <= ptr_inc(tail_r);
            end
            if (deq_s) begin
                head_r <= ptr_inc(head_r);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; contents are only observed through the count-gated head.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            pc_q_r[tail_r]   <= fetch_pc_r;
            npc_q_r[tail_r]  <= pred_s;
            inst_q_r[tail_r] <= inst_from_mem_ctrl;
        end
    end
endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench for inst_fetcher: the bench plays memory controller and issuer,
// predicts the issued stream from fetch/flush rules and compares at every dequeue.
module tb_inst_fetcher;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        is_any_full = 1'b0;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] inst_in = 32'd0;
    logic [31:0] target = 32'd0;
    logic        ready_to_issuer, req_to_mem_ctrl;
    logic [31:0] pc_to_issuer, next_pc_to_issuer, inst_to_issuer, addr_to_mem_ctrl;

    inst_fetcher #(.QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .is_any_full(is_any_full),
        .ready_to_issuer(ready_to_issuer), .pc_to_issuer(pc_to_issuer),
        .next_pc_to_issuer(next_pc_to_issuer), .inst_to_issuer(inst_to_issuer),
        .req_to_mem_ctrl(req_to_mem_ctrl), .addr_to_mem_ctrl(addr_to_mem_ctrl),
        .valid_from_mem_ctrl(valid), .inst_from_mem_ctrl(inst_in),
        .reset_from_rob_bus(flush), .target_pc_from_rob_bus(target)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] npc; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] inst; logic [31:0] off; } resp_t;

    ent_t  exp_q[$];
    resp_t forced_q[$];

    int n_checks = 0, n_pass = 0, n_deq = 0, req_count = 0;
    int knob_full = 1, knob_delay = -1, delay = 0;
    bit knob_rand = 1'b0, flush_req = 1'b0, owed = 1'b0, stale = 1'b0;
    logic [31:0] m_pc = 32'd0, req_addr = 32'd0, last_req_addr = 32'd0;
    logic [31:0] flush_tgt = 32'd0, v_off = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic logic [31:0] enc_jal(input logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12], 5'd1, 7'h6F};
    endfunction

    // Memory controller, flush source and reference model; runs just after each rising edge.
    initial begin : driver
        ent_t  e;
        resp_t r;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                exp_q.delete();
                m_pc = 32'd0; owed = 1'b0; stale = 1'b0;
                valid = 1'b0; flush = 1'b0; rdy = 1'b0; is_any_full = 1'b0;
            end else begin
                // what the edge just taken did
                if (rdy) begin
                    if (valid) begin
                        if (!flush && !stale) begin
                            e.pc = m_pc; e.npc = m_pc + v_off; e.inst = inst_in;
                            exp_q.push_back(e);
                            m_pc = m_pc + v_off;
                        end
                        owed = 1'b0;
                        stale = 1'b0;
                    end
                    if (flush) begin
                        exp_q.delete();
                        m_pc = target;
                        if (owed) stale = 1'b1;
                        chk("req_drop_on_flush", 32'(req_to_mem_ctrl), 32'd0);
                    end
                end
                if (stale) chk("req_low_in_discard", 32'(req_to_mem_ctrl), 32'd0);
                if (req_to_mem_ctrl && !owed) begin
                    chk("req_addr", addr_to_mem_ctrl, m_pc);
                    chk("req_only_with_space", 32'(exp_q.size() < DEPTH), 32'd1);
                    owed = 1'b1;
                    req_addr = addr_to_mem_ctrl;
                    last_req_addr = addr_to_mem_ctrl;
                    req_count++;
                    delay = (knob_delay < 0) ? int'($urandom_range(0, 3)) : knob_delay;
                end else if (req_to_mem_ctrl) begin
                    chk("addr_stable", addr_to_mem_ctrl, req_addr);
                end
                // inputs for the next edge
                valid = 1'b0;
                flush = 1'b0;
                rdy = knob_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
                case (knob_full)
                    0:       is_any_full = ($urandom_range(0, 3) == 0);
                    1:       is_any_full = 1'b1;
                    default: is_any_full = 1'b0;
                endcase
                if (owed) begin
                    if (delay == 0 && !flush_req) begin
                        rdy = 1'b1;
                        valid = 1'b1;
                        if (!stale && forced_q.size() > 0) begin
                            r = forced_q.pop_front();
                            inst_in = r.inst; v_off = r.off;
                        end else if ($urandom_range(0, 2) == 0) begin
                            v_off = 32'($urandom_range(0, 2047)) * 32'd2 - 32'd2048;
                            inst_in = enc_jal(v_off[20:0]);
                        end else begin
                            inst_in = $urandom;
                            if (inst_in[6:0] == 7'h6F) inst_in[3] = 1'b0;
                            v_off = 32'd4;
                        end
                    end else if (delay > 0) begin
                        delay--;
                    end
                end
                if (flush_req && rdy) begin
                    flush = 1'b1; target = flush_tgt; flush_req = 1'b0;
                end else if (knob_rand && rdy && !(valid && stale) && $urandom_range(0, 19) == 0) begin
                    flush = 1'b1; target = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                end
            end
        end
    end

    // Issuer side: pops the expected stream whenever the DUT hands off its head.
    initial begin : monitor
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("ready", 32'(ready_to_issuer), 32'(exp_q.size() != 0));
                if (rdy && exp_q.size() != 0 && !is_any_full && !flush) begin
                    e = exp_q.pop_front();
                    chk("head_pc", pc_to_issuer, e.pc);
                    chk("head_next_pc", next_pc_to_issuer, e.npc);
                    chk("head_inst", inst_to_issuer, e.inst);
                    n_deq++;
                end
            end
        end
    end

    initial begin : main
        int base, req_hi;
        resp_t r;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", 32'(ready_to_issuer), 32'd0);
        chk("rst_req", 32'(req_to_mem_ctrl), 32'd0);
        chk("rst_addr", addr_to_mem_ctrl, 32'd0);
        r.inst = 32'h0000_0013; r.off = 32'd4;
        forced_q.push_back(r);
        @(negedge clk);
        rst = 1'b1;

        // first fetch from address 0, held at the head while downstream is full
        for (int i = 0; i < 50 && !ready_to_issuer; i++) @(negedge clk);
        chk("first_head_ready", 32'(ready_to_issuer), 32'd1);
        chk("first_head_pc", pc_to_issuer, 32'd0);
        chk("first_head_next_pc", next_pc_to_issuer, 32'd4);
        chk("first_head_inst", inst_to_issuer, 32'h0000_0013);

        // saturation: queue fills, then no further requests
        repeat (60) @(negedge clk);
        req_hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_to_mem_ctrl) req_hi++;
        end
        chk("no_req_when_full", 32'(req_hi), 32'd0);
        knob_full = 2;
        repeat (30) @(negedge clk);

        // JAL at 0x10 predicts 0x18 and the next fetch goes there
        knob_full = 1;
        r.inst = 32'h0080_006F; r.off = 32'd8;
        forced_q.push_back(r);
        flush_tgt = 32'h10; flush_req = 1'b1;
        for (int i = 0; i < 20 && flush_req; i++) @(negedge clk);
        @(posedge clk); #2;
        base = req_count;
        for (int i = 0; i < 50 && !ready_to_issuer; i++) @(negedge clk);
        chk("jal_head_pc", pc_to_issuer, 32'h10);
        chk("jal_head_next_pc", next_pc_to_issuer, 32'h18);
        chk("jal_head_inst", inst_to_issuer, 32'h0080_006F);
        for (int i = 0; i < 50 && req_count < base + 2; i++) @(negedge clk);
        chk("jal_next_req_addr", last_req_addr, 32'h18);

        // flush while a fetch is pending: stale word dropped, refetch at target
        knob_full = 2; knob_delay = 4;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 50 && !owed; i++) @(negedge clk);
        flush_tgt = 32'h100; flush_req = 1'b1;
        for (int i = 0; i < 20 && flush_req; i++) @(negedge clk);
        @(posedge clk); #2;
        base = req_count;
        for (int i = 0; i < 50 && req_count < base + 1; i++) @(negedge clk);
        chk("flush_req_seen", 32'(req_count > base), 32'd1);
        chk("flush_req_addr", last_req_addr, 32'h100);
        chk("flush_queue_empty", 32'(ready_to_issuer), 32'd0);

        // asynchronous reset in the middle of a fetch with a non-empty queue
        knob_full = 1;
        for (int i = 0; i < 100 && !(ready_to_issuer && owed); i++) @(negedge clk);
        chk("pre_reset_busy", 32'(ready_to_issuer && req_to_mem_ctrl), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_req", 32'(req_to_mem_ctrl), 32'd0);
        chk("async_rst_addr", addr_to_mem_ctrl, 32'd0);
        chk("async_rst_ready", 32'(ready_to_issuer), 32'd0);
        chk("async_rst_pc", pc_to_issuer, 32'd0);
        repeat (3) @(negedge clk);
        base = req_count;
        knob_full = 2; knob_delay = -1;
        #2 rst = 1'b1;
        for (int i = 0; i < 50 && req_count < base + 1; i++) @(negedge clk);
        chk("post_reset_req_addr", last_req_addr, 32'd0);

        // randomized traffic: stalls, rdy gaps, flushes, JALs
        knob_rand = 1'b1; knob_full = 0;
        repeat (2500) @(negedge clk);
        knob_rand = 1'b0; knob_full = 2;
        repeat (40) @(negedge clk);
        chk("progress", 32'(n_deq > 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
